seg7_scan_mux: RTL and testbench

SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_mux.sv | 135 +++++++++++++
 tb/tb_seg7_scan_mux.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the 7-segment scan multiplexer.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   // Wide enough for the largest legal digit count; callers slice what they need.
   localparam logic [7:0] AN_OFF  = 8'hFF;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] result;
      result = SEG_OFF;
      case (nibble)
         4'h0: result = 7'b1000000;
         4'h1: result = 7'b1111001;
         4'h2: result = 7'b0100100;
         4'h3: result = 7'b0110000;
         4'h4: result = 7'b0011001;
         4'h5: result = 7'b0010010;
         4'h6: result = 7'b0000010;
         4'h7: result = 7'b1111000;
         4'h8: result = 7'b0000000;
         4'h9: result = 7'b0010000;
         4'hA: result = 7'b0001000;
         4'hB: result = 7'b0000011;
         4'hC: result = 7'b1000110;
         4'hD: result = 7'b0100001;
         4'hE: result = 7'b0000110;
         4'hF: result = 7'b0001110;
         default: result = SEG_OFF;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder (active-low, {g,f,e,d,c,b,a}).
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: one anode per slot, frame-synchronous data update,
// PWM brightness via DUTY, leading-zero and per-digit blanking, registered outputs.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int DUTY       = SCAN_DIV - 1
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic [NUM_DIGITS-1:0]     blank,
   input  logic                      load,
   input  logic                      lzb_en,
   output logic [NUM_DIGITS-1:0]     an,
   output logic [6:0]                seg,
   output logic                      seg_dp,
   output logic                      frame_done
);

   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0]     DUTY_CNT  = SLOT_W'(DUTY);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_NONE   = AN_OFF[NUM_DIGITS-1:0];

   logic [SLOT_W-1:0]       slot_cnt_reg, slot_cnt_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic [4*NUM_DIGITS-1:0] pend_value_reg, act_value_reg;
   logic [NUM_DIGITS-1:0]   pend_dp_reg, act_dp_reg;
   logic [NUM_DIGITS-1:0]   pend_blank_reg, act_blank_reg;
   logic [NUM_DIGITS-1:0]   an_reg, an_next;
   logic [6:0]              seg_reg, seg_next;
   logic                    seg_dp_reg, seg_dp_next;

   logic                    slot_wrap;
   logic                    frame_end;
   logic [NUM_DIGITS-1:0]   lzb_mask;
   logic [3:0]              cur_nibble;
   logic [6:0]              dec_seg;
   logic                    digit_dark;

   assign slot_wrap  = (slot_cnt_reg == SLOT_LAST);
   assign frame_end  = slot_wrap && (idx_reg == IDX_LAST);
   assign frame_done = frame_end;

   // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
   assign lzb_mask[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lzb
         assign lzb_mask[gi] = lzb_en && (act_value_reg[4*NUM_DIGITS-1:4*gi] == '0);
      end
   endgenerate

   assign cur_nibble = act_value_reg[{idx_reg, 2'b00} +: 4];

   seg7_decode u_decode (
      .nibble (cur_nibble),
      .seg    (dec_seg)
   );

   always_comb begin
      slot_cnt_next = slot_cnt_reg + 1'b1;
      idx_next      = idx_reg;
      if (slot_wrap) begin
         slot_cnt_next = '0;
         idx_next      = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end
   end

   // Slot cycle 0 is dead time so the previous digit's anode is fully off before the next lights.
   always_comb begin
      an_next     = AN_NONE;
      seg_next    = dec_seg;
      seg_dp_next = ~act_dp_reg[idx_reg];
      digit_dark  = act_blank_reg[idx_reg];
      if ((slot_cnt_reg != '0) && (slot_cnt_reg <= DUTY_CNT)) begin
         an_next[idx_reg] = 1'b0;
      end
      if (digit_dark) begin
         seg_next    = SEG_OFF;
         seg_dp_next = 1'b1;
      end else if (lzb_mask[idx_reg]) begin
         seg_next    = SEG_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt_reg   <= '0;
         idx_reg        <= '0;
         pend_value_reg <= '0;
         pend_dp_reg    <= '0;
         pend_blank_reg <= '0;
         act_value_reg  <= '0;
         act_dp_reg     <= '0;
         act_blank_reg  <= '0;
         an_reg         <= AN_NONE;
         seg_reg        <= SEG_OFF;
         seg_dp_reg     <= 1'b1;
      end else begin
         slot_cnt_reg <= slot_cnt_next;
         idx_reg      <= idx_next;
         if (load) begin
            pend_value_reg <= value;
            pend_dp_reg    <= dp;
            pend_blank_reg <= blank;
         end
         // A load on the boundary cycle bypasses the pending copy so it shows in the next frame.
         if (frame_end) begin
            if (load) begin
               act_value_reg <= value;
               act_dp_reg    <= dp;
               act_blank_reg <= blank;
            end else begin
               act_value_reg <= pend_value_reg;
               act_dp_reg    <= pend_dp_reg;
               act_blank_reg <= pend_blank_reg;
            end
         end
         an_reg     <= an_next;
         seg_reg    <= seg_next;
         seg_dp_reg <= seg_dp_next;
      end
   end

   assign an     = an_reg;
   assign seg    = seg_reg;
   assign seg_dp = seg_dp_reg;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed self-checking bench for seg7_scan_mux (4 digits, SCAN_DIV=4) with DUTY=1 and
// single-digit companion instances sharing the same stimulus.
module tb_seg7_scan_mux;

   localparam logic [6:0] S_0   = 7'b1000000;
   localparam logic [6:0] S_1   = 7'b1111001;
   localparam logic [6:0] S_2   = 7'b0100100;
   localparam logic [6:0] S_3   = 7'b0110000;
   localparam logic [6:0] S_A   = 7'b0001000;
   localparam logic [6:0] S_F   = 7'b0001110;
   localparam logic [6:0] S_OFF = 7'b1111111;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic        load;
   logic        lzb_en;

   logic [3:0]  an;
   logic [6:0]  seg;
   logic        seg_dp;
   logic        frame_done;

   logic [3:0]  an_d1;
   logic [6:0]  seg_d1;
   logic        seg_dp_d1;
   logic        frame_done_d1;

   logic [0:0]  an_s;
   logic [6:0]  seg_s;
   logic        seg_dp_s;
   logic        frame_done_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .DUTY(3)) dut (
      .clk(clk), .reset(reset), .value(value), .dp(dp), .blank(blank),
      .load(load), .lzb_en(lzb_en), .an(an), .seg(seg), .seg_dp(seg_dp),
      .frame_done(frame_done)
   );

   seg7_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .DUTY(1)) dut_duty1 (
      .clk(clk), .reset(reset), .value(value), .dp(dp), .blank(blank),
      .load(load), .lzb_en(lzb_en), .an(an_d1), .seg(seg_d1), .seg_dp(seg_dp_d1),
      .frame_done(frame_done_d1)
   );

   seg7_scan_mux #(.NUM_DIGITS(1), .SCAN_DIV(4), .DUTY(3)) dut_single (
      .clk(clk), .reset(reset), .value(value[3:0]), .dp(dp[0:0]), .blank(blank[0:0]),
      .load(load), .lzb_en(lzb_en), .an(an_s), .seg(seg_s), .seg_dp(seg_dp_s),
      .frame_done(frame_done_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns on the negedge where frame_done is high (last cycle of the last slot).
   task automatic wait_frame();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (frame_done) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) check("frame_wait_timeout", 32'd0, 32'd1);
   endtask

   // Leaves the bench at the negedge where digit 0's first lit cycle is visible.
   task automatic sync_frame();
      wait_frame();
      tick(1);
      check("frame_done_pulse", 32'(frame_done), 32'd0);
      tick(1);
      check("dead_time_an", 32'(an), 32'hF);
      tick(1);
   endtask

   task automatic check_digit(input int d, input logic [6:0] exp_seg, input logic exp_dp);
      logic [3:0] exp_an;
      exp_an = 4'b1111 ^ (4'b0001 << d);
      check($sformatf("an_d%0d", d), 32'(an), 32'(exp_an));
      check($sformatf("seg_d%0d", d), 32'(seg), 32'(exp_seg));
      check($sformatf("seg_dp_d%0d", d), 32'(seg_dp), 32'(exp_dp));
   endtask

   task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
      check_digit(0, s0, 1'b1);
      tick(4);
      check_digit(1, s1, 1'b1);
      tick(4);
      check_digit(2, s2, 1'b1);
      tick(4);
      check_digit(3, s3, 1'b1);
   endtask

   task automatic load_vals(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      value = v;
      dp    = d;
      blank = b;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   initial begin
      int pulses;
      reset  = 1'b1;
      load   = 1'b1;
      value  = 16'hFFFF;
      dp     = 4'hF;
      blank  = 4'h0;
      lzb_en = 1'b0;
      tick(3);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'(S_OFF));
      check("rst_seg_dp", 32'(seg_dp), 32'd1);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_an_duty1", 32'(an_d1), 32'hF);
      load  = 1'b0;
      value = 16'h0000;
      dp    = 4'h0;
      reset = 1'b0;

      // Single-digit instance: idx fixed at 0, so frame_done fires once per 4-cycle slot.
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (frame_done_s) pulses++;
      end
      check("single_digit_pulses", 32'(pulses), 32'd4);

      // Load asserted during reset must not have reached pending or active.
      sync_frame();
      check_frame(S_0, S_0, S_0, S_0);

      load_vals(16'h12AF, 4'h0, 4'h0);
      sync_frame();
      check_frame(S_F, S_A, S_2, S_1);

      // Mid-frame load: remainder of this frame keeps old data.
      sync_frame();
      check_digit(0, S_F, 1'b1);
      tick(4);
      check_digit(1, S_A, 1'b1);
      load_vals(16'h1111, 4'h0, 4'h0);
      tick(3);
      check_digit(2, S_2, 1'b1);
      tick(4);
      check_digit(3, S_1, 1'b1);
      sync_frame();
      check_frame(S_1, S_1, S_1, S_1);

      // Load coincident with frame_done goes straight to the following slot.
      lzb_en = 1'b1;
      wait_frame();
      load_vals(16'h0030, 4'h0, 4'h0);
      tick(2);
      check_frame(S_0, S_3, S_OFF, S_OFF);

      lzb_en = 1'b0;
      sync_frame();
      check("duty1_lit_an", 32'(an_d1), 32'hE);
      check_digit(0, S_0, 1'b1);
      tick(1);
      check("duty1_off_slot2", 32'(an_d1), 32'hF);
      check("duty3_on_slot2", 32'(an), 32'hE);
      tick(1);
      check("duty1_off_slot3", 32'(an_d1), 32'hF);
      tick(2);
      check("duty1_lit_an_d1", 32'(an_d1), 32'hD);
      check_digit(1, S_3, 1'b1);
      tick(4);
      check_digit(2, S_0, 1'b1);
      tick(4);
      check_digit(3, S_0, 1'b1);

      load_vals(16'h12AF, 4'b0110, 4'b0100);
      sync_frame();
      check_digit(0, S_F, 1'b1);
      tick(4);
      check_digit(1, S_A, 1'b0);
      tick(4);
      check("blank_an_d2", 32'(an), 32'hB);
      check("blank_seg_d2", 32'(seg), 32'(S_OFF));
      check("blank_dp_d2", 32'(seg_dp), 32'd1);
      tick(4);
      check_digit(3, S_1, 1'b1);

      // Reset at idx=2, slot_cnt=2 restarts the scan at digit 0 with cleared data.
      sync_frame();
      tick(8);
      check("pre_reset_an", 32'(an), 32'hB);
      reset = 1'b1;
      tick(1);
      check("mid_rst_an", 32'(an), 32'hF);
      check("mid_rst_seg", 32'(seg), 32'(S_OFF));
      check("mid_rst_seg_dp", 32'(seg_dp), 32'd1);
      check("mid_rst_frame_done", 32'(frame_done), 32'd0);
      reset = 1'b0;
      tick(1);
      check("post_rst_dead_an", 32'(an), 32'hF);
      tick(1);
      check_digit(0, S_0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
